lcd_init_seq: RTL

- Power-up initialisation sequencer for the LCD path. It drives the panel hardware-reset pin, then replays a command/data/delay script from a ROM.
- Each script write is issued to lcd_interface, routed through the lcd_mux init_* inputs while init_finish=0.
- It raises a sticky init_finish when the script ends; lcd_mux then hands the interface over to lcd_id.

---
 rtl/lcd_pkg.sv | 53 +++++
 rtl/lcd_init_rom.sv | 21 ++
 rtl/lcd_init_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and default panel script for the LCD init sequencer
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } init_op_t;

  typedef struct packed {
    init_op_t    op;
    logic [15:0] payload;
  } init_entry_t;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_DELAY,
    ST_DONE
  } lcd_init_state_t;

  // Script storage is sized for the largest supported ROM; smaller ROMs use the low entries.
  localparam int SCRIPT_AW    = 7;
  localparam int SCRIPT_DEPTH = 1 << SCRIPT_AW;

  typedef init_entry_t [SCRIPT_DEPTH-1:0] script_t;

  function automatic init_entry_t mk_entry(init_op_t op, logic [15:0] payload);
    init_entry_t e;
    e.op      = op;
    e.payload = payload;
    return e;
  endfunction

  function automatic script_t default_script();
    script_t s;
    for (int i = 0; i < SCRIPT_DEPTH; i++) s[SCRIPT_AW'(i)] = mk_entry(OP_END, 16'h0000);
    s[7'd0] = mk_entry(OP_CMD,   16'h0011);  // sleep out
    s[7'd1] = mk_entry(OP_DELAY, 16'd120);
    s[7'd2] = mk_entry(OP_CMD,   16'h003A);  // pixel format: 16 bpp
    s[7'd3] = mk_entry(OP_DATA,  16'h0055);
    s[7'd4] = mk_entry(OP_CMD,   16'h0036);  // memory access control
    s[7'd5] = mk_entry(OP_DATA,  16'h0000);
    s[7'd6] = mk_entry(OP_CMD,   16'h0029);  // display on
    s[7'd7] = mk_entry(OP_END,   16'h0000);
    return s;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// rtl/lcd_init_rom.sv - synchronous-read script ROM for the LCD init sequencer
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int      ROM_AW = 7,
  parameter script_t SCRIPT = default_script()
) (
  input  logic              pclk,
  input  logic [ROM_AW-1:0] addr,
  output init_entry_t       q
);

  logic [SCRIPT_AW-1:0] idx;

  assign idx = SCRIPT_AW'(addr);

  always_ff @(posedge pclk) begin
    q <= SCRIPT[idx];
  end

endmodule

// File: rtl/lcd_init_seq.sv
// rtl/lcd_init_seq.sv - panel hardware reset followed by a ROM-driven command/data/delay script
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int      CLK_PER_MS  = 50000,
  parameter int      RST_LOW_MS  = 10,
  parameter int      RST_WAIT_MS = 120,
  parameter int      ROM_AW      = 7,
  parameter script_t SCRIPT      = default_script()
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        init_write_ok,
  output logic [15:0] init_data,
  output logic        init_we,
  output logic        init_wr,
  output logic        init_rs,
  output logic        init_work,
  output logic        init_finish,
  output logic        lcd_rst_o
);

  localparam int            TW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_MS - 1);

  lcd_init_state_t   state_q, state_d;
  logic [ROM_AW-1:0] pc_q, pc_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [15:0]       ms_q, ms_d;
  logic [15:0]       delay_ms_q, delay_ms_d;
  logic [15:0]       data_q, data_d;
  logic              rs_q, rs_d;
  logic              we_q, we_d;
  logic              wr_q, wr_d;
  logic              work_q, work_d;
  logic              finish_q, finish_d;
  logic              lcd_rst_q, lcd_rst_d;

  init_entry_t       rom_q;
  logic [15:0]       target_ms;
  logic              ms_tick;
  logic              timer_done;
  logic              pc_last;

  lcd_init_rom #(
    .ROM_AW (ROM_AW),
    .SCRIPT (SCRIPT)
  ) u_rom (
    .pclk (pclk),
    .addr (pc_q),
    .q    (rom_q)
  );

  // One shared ms timebase serves both reset phases and script delays; a zero target ends at once.
  always_comb begin
    target_ms = delay_ms_q;
    if (state_q == ST_RST_LOW)       target_ms = 16'(RST_LOW_MS);
    else if (state_q == ST_RST_WAIT) target_ms = 16'(RST_WAIT_MS);
    ms_tick    = (tick_q == TICK_LAST);
    timer_done = (target_ms == 16'd0) || (ms_tick && (ms_q == target_ms - 16'd1));
    pc_last    = &pc_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tick_d     = tick_q;
    ms_d       = ms_q;
    delay_ms_d = delay_ms_q;
    data_d     = data_q;
    rs_d       = rs_q;
    we_d       = we_q;

    if (state_q inside {ST_RST_LOW, ST_RST_WAIT, ST_DELAY}) begin
      if (ms_tick) begin
        tick_d = '0;
        ms_d   = ms_q + 16'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    unique case (state_q)
      ST_RST_LOW:  if (timer_done) state_d = ST_RST_WAIT;
      ST_RST_WAIT: if (timer_done) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (rom_q.op)
          OP_CMD, OP_DATA: begin
            data_d  = rom_q.payload;
            rs_d    = rom_q.op[0];
            we_d    = 1'b1;
            state_d = ST_WRITE;
          end
          OP_DELAY: begin
            delay_ms_d = rom_q.payload;
            state_d    = ST_DELAY;
          end
          OP_END: state_d = ST_DONE;
        endcase
      end
      ST_WRITE: begin
        if (init_write_ok) begin
          we_d    = 1'b0;
          pc_d    = pc_last ? pc_q : pc_q + ROM_AW'(1);
          state_d = pc_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DELAY: begin
        if (timer_done) begin
          pc_d    = pc_last ? pc_q : pc_q + ROM_AW'(1);
          state_d = pc_last ? ST_DONE : ST_FETCH;
        end
      end
      default: ;
    endcase

    if (state_d != state_q) begin
      tick_d = '0;
      ms_d   = '0;
    end

    wr_d      = 1'b1;
    work_d    = (state_d != ST_DONE);
    finish_d  = (state_d == ST_DONE);
    lcd_rst_d = (state_d != ST_RST_LOW);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= ST_RST_LOW;
      pc_q       <= '0;
      tick_q     <= '0;
      ms_q       <= '0;
      delay_ms_q <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      we_q       <= 1'b0;
      wr_q       <= 1'b0;
      work_q     <= 1'b0;
      finish_q   <= 1'b0;
      lcd_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tick_q     <= tick_d;
      ms_q       <= ms_d;
      delay_ms_q <= delay_ms_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      we_q       <= we_d;
      wr_q       <= wr_d;
      work_q     <= work_d;
      finish_q   <= finish_d;
      lcd_rst_q  <= lcd_rst_d;
    end
  end

  assign init_data   = data_q;
  assign init_we     = we_q;
  assign init_wr     = wr_q;
  assign init_rs     = rs_q;
  assign init_work   = work_q;
  assign init_finish = finish_q;
  assign lcd_rst_o   = lcd_rst_q;

endmodule
